disp_sched: RTL and testbench
=============================

DISP_SCHED -- requirements
Module: disp_sched

Interface
REQ-001 Parameter DIV, default 24000000, system clocks per scroll step.
REQ-002 Parameter PASSES, default 1, full message rotations shown per grant.
REQ-003 Parameter NREQ, fixed 3, number of requesters.
REQ-004 clk  in  1  system clock, the only clock.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 req  in  3  per-requester level request; bit i belongs to requester i.
REQ-007 msg0, msg1, msg2  in  70 each  14 chars x 5-bit codes, char 0 in [69:65].
REQ-008 grant  out  3  one-hot owner of the display; 0 when idle.
REQ-009 done  out  3  one-cycle pulse to the requester whose display completed.
REQ-010 busy  out  1  high while any grant is held.
REQ-011 data  out  20  four 5-bit digit codes to the display, leftmost digit in [19:15].

Function
REQ-012 States SHALL be IDLE, SCROLL and DONE, encoded in 2 bits.
REQ-013 IDLE: data = 20'hFFFFF (four blank codes 5'd31); grant = 0; busy = 0.
REQ-014 IDLE with any req bit set: at the next edge, grant the winner, latch its msg into a 70-bit shift register, clear the tick and step counters, and enter SCROLL.
REQ-015 Arbitration SHALL be round-robin, searching from the index after the last granted requester. After reset the search starts at requester 0.
REQ-016 SCROLL: data = shift[69:50]. Grant and busy are valid in the same cycle as the first data.
REQ-017 The tick counter SHALL count 0..DIV-1 and emit a tick when it equals DIV-1. It wraps to 0 on the tick. The first tick occurs DIV cycles after SCROLL entry.
REQ-018 On each tick: shift <= {shift[64:0], shift[69:65]}, a 5-bit left rotate with wrap-around, and the step counter increments.
REQ-019 The step counter SHALL reach 14*PASSES. When the tick reaching that count occurs, enter DONE.
REQ-020 DONE lasts exactly one cycle. done[owner] = 1, grant = 0, busy = 0, data blank. The arbiter pointer is updated, then the block returns to IDLE.
REQ-021 The granted req dropping during SCROLL SHALL abort: next state IDLE, no done pulse, pointer still advanced.
REQ-022 Changes on msgN after the grant SHALL be ignored. Only the latched copy is displayed.
REQ-023 Requests from non-owners during SCROLL are held pending and are not lost while their req stays high.
REQ-024 A requester still holding req in DONE competes normally in the next IDLE cycle.
REQ-025 DIV = 1 SHALL tick every cycle.

Reset
REQ-026 rst SHALL put the block in IDLE with grant = 0, done = 0, busy = 0, data = 20'hFFFFF, counters 0 and pointer 0.
REQ-027 rst asserted mid-SCROLL SHALL take effect at the next edge and SHALL NOT emit a done pulse.

Structure
REQ-028 The state encodings, the blank code 5'd31 and the 14-char message length SHALL live in the shared package, disp_pkg.
REQ-029 The tick divider SHALL be one sub-module, tick_gen (clk, rst, clr, div, tick). All other logic stays flat in disp_sched.

Verification (DIV = 4, PASSES = 1 unless stated)
REQ-030 Single requester: req = 001 with msg0 = codes {31,31,31,31,12,10,18,12,24,18,10,23,0,22}.
- grant = 001 one cycle later; data = 20'hFFFFF.
- After 4 cycles, data = {31,31,31,12}.
- After 56 cycles, done = 001 for one cycle, then IDLE.
REQ-031 Contention: req = 101 out of reset.
- grant 001 first, done[0] after 56 cycles.
- With req[0] dropped, grant 100 two cycles after done[0].
REQ-032 Fairness: req = 111 held constant. Grant order SHALL be 001, 100, 010, 001 across successive grants.
REQ-033 Abort: req0 drops 10 cycles into SCROLL. The block is IDLE with blank data next cycle; no done pulse.
REQ-034 Reset mid-SCROLL: rst for one cycle at cycle 20. All outputs are at reset values the next cycle; no done pulse.
REQ-035 PASSES = 2:
- data after 56 cycles equals the initial data (rotation wrapped).
- done pulses after 112 cycles.

Source files
------------

// File: rtl/disp_pkg.sv
// ---------------------------------------------------------------------------
// disp_pkg
// Shared definitions for the scrolling-display scheduler:
//   - scheduler state encoding (2 bits)
//   - character code width, message length and the blank code
//   - small helpers for message rotation, requester index stepping and
//     one-hot decoding
// No ports; imported by disp_sched.
// ---------------------------------------------------------------------------
package disp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SCROLL = 2'd1,
      ST_DONE   = 2'd2
   } disp_state_t;

   localparam int CHAR_W    = 5;
   localparam int MSG_CHARS = 14;
   localparam int MSG_W     = CHAR_W * MSG_CHARS;   // 70
   localparam int DIGITS    = 4;
   localparam int DATA_W    = CHAR_W * DIGITS;      // 20

   localparam logic [CHAR_W-1:0] BLANK_CODE = 5'd31;
   localparam logic [DATA_W-1:0] DATA_BLANK = {DIGITS{BLANK_CODE}};
   localparam logic [MSG_W-1:0]  MSG_BLANK  = {MSG_CHARS{BLANK_CODE}};

   // One-character left rotate: the leading character moves to the tail.
   function automatic logic [MSG_W-1:0] rotate_char(input logic [MSG_W-1:0] v);
      return {v[MSG_W-CHAR_W-1:0], v[MSG_W-1:MSG_W-CHAR_W]};
   endfunction

   // Requester index one step "down" with wrap: 0 -> 2 -> 1 -> 0.
   function automatic logic [1:0] dec_mod3(input logic [1:0] i);
      logic [1:0] r;
      case (i)
         2'd0:    r = 2'd2;
         2'd1:    r = 2'd0;
         2'd2:    r = 2'd1;
         default: r = 2'd0;
      endcase
      return r;
   endfunction

   // Requester index to one-hot bit mask.
   function automatic logic [2:0] idx_onehot(input logic [1:0] i);
      logic [2:0] r;
      case (i)
         2'd0:    r = 3'b001;
         2'd1:    r = 3'b010;
         2'd2:    r = 3'b100;
         default: r = 3'b000;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/tick_gen.sv
// ---------------------------------------------------------------------------
// tick_gen
// Free-running divider that pulses tick once every 'div' clocks.
// Ports:
//   clk  in   system clock
//   rst  in   synchronous active-high reset
//   clr  in   holds the count at 0 (and suppresses tick) while high
//   div  in   32-bit period in clocks; 1 gives a tick every cycle
//   tick out  high during the cycle in which the count equals div-1
// The first tick after clr drops arrives exactly 'div' cycles later.
// ---------------------------------------------------------------------------
module tick_gen (
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic [31:0] div,
   output logic        tick
);

   logic [31:0] cnt_r;
   logic        at_end_s;

   assign at_end_s = (cnt_r == (div - 32'd1));
   assign tick     = at_end_s & ~clr;

   // Period counter: 0..div-1, wraps on the tick, parked at 0 by clr.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r <= 32'd0;
      end else if (clr) begin
         cnt_r <= 32'd0;
      end else if (at_end_s) begin
         cnt_r <= 32'd0;
      end else begin
         cnt_r <= cnt_r + 32'd1;
      end
   end

endmodule

// File: rtl/disp_sched.sv
// ---------------------------------------------------------------------------
// disp_sched
// Shares one 4-digit scrolling display among three requesters. A winner is
// picked round-robin, its 14-character message is latched and scrolled one
// character every DIV clocks for PASSES full rotations, then the owner gets
// a one-cycle done pulse.
// Parameters:
//   DIV     clocks per scroll step
//   PASSES  full message rotations per grant
//   NREQ    number of requesters (fixed at 3)
// Ports:
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   req[2:0]     in   level requests, bit i = requester i
//   msg0..msg2   in   70-bit messages, char 0 in [69:65]
//   grant[2:0]   out  one-hot display owner, 0 when idle
//   done[2:0]    out  one-cycle completion pulse to the owner
//   busy         out  high while a grant is held
//   data[19:0]   out  four digit codes, leftmost in [19:15]
// All outputs are registered; they are loaded from the next-state values so
// grant, busy and the first data word appear together.
// ---------------------------------------------------------------------------
module disp_sched
   import disp_pkg::*;
#(
   parameter int DIV    = 24000000,
   parameter int PASSES = 1,
   parameter int NREQ   = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req,
   input  logic [MSG_W-1:0]  msg0,
   input  logic [MSG_W-1:0]  msg1,
   input  logic [MSG_W-1:0]  msg2,
   output logic [NREQ-1:0]   grant,
   output logic [NREQ-1:0]   done,
   output logic              busy,
   output logic [DATA_W-1:0] data
);

   localparam logic [31:0] DIV_W     = 32'(DIV);
   localparam logic [15:0] STEP_LAST = 16'(MSG_CHARS * PASSES - 1);

   disp_state_t        state_r,  state_nxt_s;
   logic [1:0]         owner_r,  owner_nxt_s;
   logic [1:0]         ptr_r,    ptr_nxt_s;
   logic [MSG_W-1:0]   shift_r,  shift_nxt_s;
   logic [15:0]        step_r,   step_nxt_s;

   logic               win_vld_s;
   logic [1:0]         win_idx_s;
   logic [1:0]         cand1_s;
   logic [1:0]         cand2_s;
   logic [MSG_W-1:0]   win_msg_s;

   logic               tick_s;
   logic               clr_s;

   logic [NREQ-1:0]    grant_r, grant_nxt_s;
   logic [NREQ-1:0]    done_r,  done_nxt_s;
   logic               busy_r,  busy_nxt_s;
   logic [DATA_W-1:0]  data_r,  data_nxt_s;

   // The divider only runs while scrolling, so it restarts from 0 on every
   // new grant and the first step lands DIV cycles after entry.
   assign clr_s = (state_r != ST_SCROLL);

   tick_gen u_tick (
      .clk  (clk),
      .rst  (rst),
      .clr  (clr_s),
      .div  (DIV_W),
      .tick (tick_s)
   );

   // Round-robin pick: try ptr_r first, then walk downward with wrap.
   // After owner k finishes, ptr_r becomes k-1, giving order 0 -> 2 -> 1.
   always_comb begin
      cand1_s   = dec_mod3(ptr_r);
      cand2_s   = dec_mod3(cand1_s);
      win_vld_s = 1'b0;
      win_idx_s = ptr_r;
      if (req[ptr_r]) begin
         win_vld_s = 1'b1;
         win_idx_s = ptr_r;
      end else if (req[cand1_s]) begin
         win_vld_s = 1'b1;
         win_idx_s = cand1_s;
      end else if (req[cand2_s]) begin
         win_vld_s = 1'b1;
         win_idx_s = cand2_s;
      end else begin
         win_vld_s = 1'b0;
         win_idx_s = ptr_r;
      end
   end

   // Message of the current arbitration winner.
   always_comb begin
      win_msg_s = MSG_BLANK;
      case (win_idx_s)
         2'd0:    win_msg_s = msg0;
         2'd1:    win_msg_s = msg1;
         2'd2:    win_msg_s = msg2;
         default: win_msg_s = MSG_BLANK;
      endcase
   end

   // Next-state logic for the scheduler and its datapath registers.
   always_comb begin
      state_nxt_s = state_r;
      owner_nxt_s = owner_r;
      ptr_nxt_s   = ptr_r;
      shift_nxt_s = shift_r;
      step_nxt_s  = step_r;
      case (state_r)
         ST_IDLE: begin
            if (win_vld_s) begin
               state_nxt_s = ST_SCROLL;
               owner_nxt_s = win_idx_s;
               shift_nxt_s = win_msg_s;
               step_nxt_s  = 16'd0;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_SCROLL: begin
            // Owner withdrawing wins over a coincident final step: no done.
            if (!req[owner_r]) begin
               state_nxt_s = ST_IDLE;
               ptr_nxt_s   = dec_mod3(owner_r);
            end else if (tick_s) begin
               shift_nxt_s = rotate_char(shift_r);
               step_nxt_s  = step_r + 16'd1;
               if (step_r == STEP_LAST) begin
                  state_nxt_s = ST_DONE;
               end else begin
                  state_nxt_s = ST_SCROLL;
               end
            end else begin
               state_nxt_s = ST_SCROLL;
            end
         end
         ST_DONE: begin
            state_nxt_s = ST_IDLE;
            ptr_nxt_s   = dec_mod3(owner_r);
         end
         default: begin
            state_nxt_s = ST_IDLE;
            ptr_nxt_s   = 2'd0;
         end
      endcase
   end

   // Output values for the coming cycle, decoded from the next state.
   always_comb begin
      grant_nxt_s = 3'b000;
      done_nxt_s  = 3'b000;
      busy_nxt_s  = 1'b0;
      data_nxt_s  = DATA_BLANK;
      case (state_nxt_s)
         ST_SCROLL: begin
            grant_nxt_s = idx_onehot(owner_nxt_s);
            busy_nxt_s  = 1'b1;
            data_nxt_s  = shift_nxt_s[MSG_W-1:MSG_W-DATA_W];
         end
         ST_DONE: begin
            done_nxt_s = idx_onehot(owner_nxt_s);
         end
         default: begin
            data_nxt_s = DATA_BLANK;
         end
      endcase
   end

   // State, datapath and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
         owner_r <= 2'd0;
         ptr_r   <= 2'd0;
         shift_r <= MSG_BLANK;
         step_r  <= 16'd0;
         grant_r <= 3'b000;
         done_r  <= 3'b000;
         busy_r  <= 1'b0;
         data_r  <= DATA_BLANK;
      end else begin
         state_r <= state_nxt_s;
         owner_r <= owner_nxt_s;
         ptr_r   <= ptr_nxt_s;
         shift_r <= shift_nxt_s;
         step_r  <= step_nxt_s;
         grant_r <= grant_nxt_s;
         done_r  <= done_nxt_s;
         busy_r  <= busy_nxt_s;
         data_r  <= data_nxt_s;
      end
   end

   assign grant = grant_r;
   assign done  = done_r;
   assign busy  = busy_r;
   assign data  = data_r;

endmodule

// File: tb/tb_disp_sched.sv
// ---------------------------------------------------------------------------
// tb_disp_sched
// Self-checking bench for disp_sched. Three instances: DIV=4/PASSES=1 (main,
// tracked every cycle by a reference model), DIV=4/PASSES=2, DIV=1/PASSES=1.
// The reference model keeps the owner, the latched message and the number of
// cycles spent scrolling; the expected window is the message read at offset
// (cycles / DIV) mod 14.
// ---------------------------------------------------------------------------
module tb_disp_sched;

   localparam int DIVT       = 4;
   localparam int SCROLL_LEN = 14 * DIVT;
   localparam logic [19:0] BLANK = 20'hFFFFF;
   localparam logic [69:0] M0 = {5'd31, 5'd31, 5'd31, 5'd31, 5'd12, 5'd10, 5'd18,
                                 5'd12, 5'd24, 5'd18, 5'd10, 5'd23, 5'd0,  5'd22};

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  req, req2, req3;
   logic [69:0] msg0, msg1, msg2;
   logic [2:0]  grant, done, grant2, done2, grant3, done3;
   logic        busy, busy2, busy3;
   logic [19:0] data, data2, data3;

   int total = 0;
   int bad   = 0;

   // reference model state
   int          m_mode;   // 0 idle, 1 scrolling, 2 done
   int          m_owner;
   int          m_ptr;
   int          m_e;
   logic [69:0] m_msg;

   always #5 clk = ~clk;

   disp_sched #(.DIV(4), .PASSES(1), .NREQ(3)) dut (
      .clk(clk), .rst(rst), .req(req), .msg0(msg0), .msg1(msg1), .msg2(msg2),
      .grant(grant), .done(done), .busy(busy), .data(data));

   disp_sched #(.DIV(4), .PASSES(2), .NREQ(3)) dut2 (
      .clk(clk), .rst(rst), .req(req2), .msg0(msg0), .msg1(msg1), .msg2(msg2),
      .grant(grant2), .done(done2), .busy(busy2), .data(data2));

   disp_sched #(.DIV(1), .PASSES(1), .NREQ(3)) dut3 (
      .clk(clk), .rst(rst), .req(req3), .msg0(msg0), .msg1(msg1), .msg2(msg2),
      .grant(grant3), .done(done3), .busy(busy3), .data(data3));

   typedef struct {
      logic [2:0]  req;
      int          ncyc;
      logic [2:0]  grant;
      logic [2:0]  done;
      logic        busy;
      logic [19:0] data;
   } vec_t;

   vec_t tbl[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [69:0] rand70();
      logic [95:0] t;
      t = {$urandom(), $urandom(), $urandom()};
      return t[69:0];
   endfunction

   function automatic logic [4:0] mchar(input logic [69:0] m, input int i);
      return m[69-5*i -: 5];
   endfunction

   function automatic logic [2:0] m_grant();
      return (m_mode == 1) ? 3'(3'b001 << m_owner) : 3'b000;
   endfunction

   function automatic logic [2:0] m_done();
      return (m_mode == 2) ? 3'(3'b001 << m_owner) : 3'b000;
   endfunction

   function automatic logic [19:0] m_data();
      int k;
      if (m_mode != 1) return BLANK;
      k = (m_e / DIVT) % 14;
      return {mchar(m_msg, k), mchar(m_msg, (k + 1) % 14),
              mchar(m_msg, (k + 2) % 14), mchar(m_msg, (k + 3) % 14)};
   endfunction

   // advance the model by one clock using the inputs the DUT just sampled
   task automatic model_step();
      int   c;
      logic found;
      found = 1'b0;
      if (rst) begin
         m_mode = 0; m_ptr = 0; m_e = 0; m_owner = 0;
      end else if (m_mode == 0) begin
         for (int j = 0; j < 3; j++) begin
            c = (m_ptr - j + 3) % 3;
            if (!found && req[2'(c)]) begin
               found   = 1'b1;
               m_owner = c;
            end
         end
         if (found) begin
            m_mode = 1;
            m_e    = 0;
            m_msg  = (m_owner == 0) ? msg0 : (m_owner == 1) ? msg1 : msg2;
         end
      end else if (m_mode == 1) begin
         if (!req[2'(m_owner)]) begin
            m_mode = 0;
            m_ptr  = (m_owner + 2) % 3;
         end else begin
            m_e++;
            if (m_e == SCROLL_LEN) m_mode = 2;
         end
      end else begin
         m_mode = 0;
         m_ptr  = (m_owner + 2) % 3;
      end
   endtask

   // one clock: model follows the edge, outputs compared on the falling edge
   task automatic cyc();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check("model grant", 32'(grant), 32'(m_grant()));
      check("model done",  32'(done),  32'(m_done()));
      check("model busy",  32'(busy),  32'(m_mode == 1));
      check("model data",  32'(data),  32'(m_data()));
   endtask

   task automatic cycn(input int n);
      repeat (n) cyc();
   endtask

   task automatic do_reset();
      rst = 1'b1; req = 3'b000; req2 = 3'b000; req3 = 3'b000;
      msg0 = M0;
      cycn(2);
      rst = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0] fair_exp [4];
      int         n;
      int         idx;

      msg0 = M0; msg1 = rand70(); msg2 = rand70();
      m_mode = 0; m_ptr = 0; m_e = 0; m_owner = 0; m_msg = M0;

      // single requester, checked against fixed vectors
      tbl[0] = '{req: 3'b000, ncyc: 1,  grant: 3'b000, done: 3'b000, busy: 1'b0, data: BLANK};
      tbl[1] = '{req: 3'b001, ncyc: 1,  grant: 3'b001, done: 3'b000, busy: 1'b1, data: BLANK};
      tbl[2] = '{req: 3'b001, ncyc: 4,  grant: 3'b001, done: 3'b000, busy: 1'b1,
                 data: {5'd31, 5'd31, 5'd31, 5'd12}};
      tbl[3] = '{req: 3'b001, ncyc: 4,  grant: 3'b001, done: 3'b000, busy: 1'b1,
                 data: {5'd31, 5'd31, 5'd12, 5'd10}};
      tbl[4] = '{req: 3'b001, ncyc: 44, grant: 3'b001, done: 3'b000, busy: 1'b1,
                 data: {5'd22, 5'd31, 5'd31, 5'd31}};
      tbl[5] = '{req: 3'b001, ncyc: 3,  grant: 3'b001, done: 3'b000, busy: 1'b1,
                 data: {5'd22, 5'd31, 5'd31, 5'd31}};
      tbl[6] = '{req: 3'b001, ncyc: 1,  grant: 3'b000, done: 3'b001, busy: 1'b0, data: BLANK};
      tbl[7] = '{req: 3'b000, ncyc: 1,  grant: 3'b000, done: 3'b000, busy: 1'b0, data: BLANK};

      do_reset();
      for (int i = 0; i < 8; i++) begin
         req = tbl[i].req;
         cycn(tbl[i].ncyc);
         check($sformatf("vec%0d grant", i), 32'(grant), 32'(tbl[i].grant));
         check($sformatf("vec%0d done", i),  32'(done),  32'(tbl[i].done));
         check($sformatf("vec%0d busy", i),  32'(busy),  32'(tbl[i].busy));
         check($sformatf("vec%0d data", i),  32'(data),  32'(tbl[i].data));
         // the live message input changes after the grant; only the copy shows
         if (i == 1) msg0 = rand70();
      end
      msg0 = M0;

      // contention: 0 first, then 2 once 0 withdraws
      do_reset();
      req = 3'b101;
      cyc();
      check("cont first grant", 32'(grant), 32'h1);
      cycn(SCROLL_LEN - 1);
      cyc();
      check("cont done0", 32'(done), 32'h1);
      req = 3'b100;
      cyc();
      check("cont gap grant", 32'(grant), 32'h0);
      cyc();
      check("cont second grant", 32'(grant), 32'h4);
      req = 3'b000;
      cycn(2);

      // fairness with all three requesting
      fair_exp[0] = 3'b001; fair_exp[1] = 3'b100; fair_exp[2] = 3'b010; fair_exp[3] = 3'b001;
      do_reset();
      req = 3'b111;
      for (int g = 0; g < 4; g++) begin
         n = 0;
         while (grant == 3'b000 && n < 10) begin cyc(); n++; end
         check($sformatf("fair grant%0d", g), 32'(grant), 32'(fair_exp[g]));
         n = 0;
         while (done == 3'b000 && n < 70) begin cyc(); n++; end
         check($sformatf("fair done%0d", g), 32'(done), 32'(fair_exp[g]));
      end
      req = 3'b000;
      cycn(2);

      // abort: owner drops its request mid-scroll
      do_reset();
      req = 3'b001;
      cyc();
      check("abort grant", 32'(grant), 32'h1);
      cycn(10);
      req = 3'b000;
      cyc();
      check("abort grant off", 32'(grant), 32'h0);
      check("abort busy off",  32'(busy),  32'h0);
      check("abort data",      32'(data),  32'(BLANK));
      for (int i = 0; i < 3; i++) begin
         check("abort no done", 32'(done), 32'h0);
         cyc();
      end

      // reset while scrolling
      do_reset();
      req = 3'b001;
      cycn(20);
      rst = 1'b1;
      cyc();
      check("rst grant", 32'(grant), 32'h0);
      check("rst done",  32'(done),  32'h0);
      check("rst busy",  32'(busy),  32'h0);
      check("rst data",  32'(data),  32'(BLANK));
      rst = 1'b0; req = 3'b000;
      for (int i = 0; i < 3; i++) begin
         cyc();
         check("rst no done", 32'(done), 32'h0);
      end

      // two passes per grant
      req2 = 3'b001;
      cyc();
      check("p2 grant", 32'(grant2), 32'h1);
      check("p2 data0", 32'(data2), 32'(BLANK));
      cycn(4);
      check("p2 data4", 32'(data2), 32'({5'd31, 5'd31, 5'd31, 5'd12}));
      cycn(52);
      check("p2 wrapped data", 32'(data2), 32'(BLANK));
      check("p2 still granted", 32'(grant2), 32'h1);
      cycn(55);
      check("p2 no early done", 32'(done2), 32'h0);
      cyc();
      check("p2 done", 32'(done2), 32'h1);
      req2 = 3'b000;
      cyc();
      check("p2 done one cycle", 32'(done2), 32'h0);

      // DIV = 1: a step every cycle
      req3 = 3'b001;
      cyc();
      check("d1 grant", 32'(grant3), 32'h1);
      cyc();
      check("d1 data1", 32'(data3), 32'({5'd31, 5'd31, 5'd31, 5'd12}));
      cycn(12);
      check("d1 still granted", 32'(grant3), 32'h1);
      cyc();
      check("d1 done", 32'(done3), 32'h1);
      req3 = 3'b000;
      cyc();

      // random traffic against the model
      do_reset();
      for (int t = 0; t < 4000; t++) begin
         if ($urandom_range(0, 39) == 0) begin
            idx = $urandom_range(0, 2);
            req[idx] = ~req[idx];
         end
         if ($urandom_range(0, 3) == 0) msg0 = rand70();
         if ($urandom_range(0, 3) == 0) msg1 = rand70();
         if ($urandom_range(0, 3) == 0) msg2 = rand70();
         rst = ($urandom_range(0, 999) == 0);
         cyc();
      end
      rst = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
